// File: rtl/alu_pkg.sv
// Shared opcode encodings, default widths and the queued command record for the ALU command path.
package alu_pkg;

  localparam int DW_DEF  = 4;
  localparam int OPW_DEF = 3;

  localparam logic [OPW_DEF-1:0] OP_ADD = 3'b000;
  localparam logic [OPW_DEF-1:0] OP_SUB = 3'b001;
  localparam logic [OPW_DEF-1:0] OP_AND = 3'b010;
  localparam logic [OPW_DEF-1:0] OP_OR  = 3'b011;
  localparam logic [OPW_DEF-1:0] OP_NOT = 3'b100;
  localparam logic [OPW_DEF-1:0] OP_MAX = 3'b100;

  typedef struct packed {
    logic [OPW_DEF-1:0] op;
    logic [DW_DEF-1:0]  a;
    logic [DW_DEF-1:0]  b;
  } cmd_t;

  function automatic logic op_legal(input logic [OPW_DEF-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Producer command port and completed-result port of the ALU command queue.
interface alu_cmd_queue_if #(
  parameter int DW  = 4,
  parameter int OPW = 3
) ();
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic [OPW-1:0] res_op;

  modport master (
    output in_valid, in_op, in_a, in_b,
    input  in_ready, res_valid, res_data, res_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    output in_ready, res_valid, res_data, res_op
  );
endinterface

// File: rtl/alu_cmd_queue_fifo.sv
// Generic DEPTH x W synchronous FIFO; push ignored when full, pop ignored when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue and issue stage in front of the 4-bit ALU; pairs registered ALU results with their opcodes.
// Optional `ALU_OPCODE_CHECK_EN drops opcodes above OP_MAX and raises a sticky err_illegal.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DW      = DW_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_queue_if.slave         cq,
  input  logic                   issue_en,
  output logic [OPW-1:0]         alu_op,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  input  logic [DW-1:0]          alu_result,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_illegal
);
  typedef struct packed {
    logic           v;
    logic [OPW-1:0] op;
  } tag_t;

  cmd_t  in_cmd, head;
  logic  full, empty, accept, illegal, push, pop;
  tag_t  tags [ALU_LAT+1];

  always_comb begin
    in_cmd    = '0;
    in_cmd.op = cq.in_op;
    in_cmd.a  = cq.in_a;
    in_cmd.b  = cq.in_b;
  end

  assign cq.in_ready = !full;
  assign accept      = cq.in_valid && cq.in_ready;
  assign push        = accept && !illegal;
  assign pop         = issue_en && !empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (pop) begin
      alu_op <= head.op;
      alu_a  <= head.a;
      alu_b  <= head.b;
    end
  end

  // Tag reaches the last stage as the ALU result registers; the output stage then samples both together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ALU_LAT + 1; i++) tags[i] <= '0;
      cq.res_valid <= 1'b0;
      cq.res_data  <= '0;
      cq.res_op    <= '0;
    end else begin
      tags[0].v  <= pop;
      tags[0].op <= head.op;
      for (int unsigned i = 1; i < ALU_LAT + 1; i++) tags[i] <= tags[i-1];
      cq.res_valid <= tags[ALU_LAT].v;
      if (tags[ALU_LAT].v) begin
        cq.res_data <= alu_result;
        cq.res_op   <= tags[ALU_LAT].op;
      end
    end
  end

`ifdef ALU_OPCODE_CHECK_EN
  assign illegal = !op_legal(cq.in_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err_illegal <= 1'b0;
    else if (accept && illegal) err_illegal <= 1'b1;
  end
`else
  assign illegal     = 1'b0;
  assign err_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed self-checking bench for alu_cmd_queue with a one-cycle registered ALU model.
module tb_alu_cmd_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic       issue_en;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] level;
  logic       err_illegal;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [3:0] log_d [$];
  logic [2:0] log_o [$];
  int         log_c [$];

  alu_cmd_queue_if #(.DW(4), .OPW(3)) cq ();

  alu_cmd_queue #(
    .DEPTH   (4),
    .DW      (4),
    .OPW     (3),
    .ALU_LAT (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cq          (cq),
    .issue_en    (issue_en),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .level       (level),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: result registered one clock after its inputs change.
  initial alu_result = '0;
  always @(posedge clk) begin
    case (alu_op)
      3'b000:  alu_result <= alu_a + alu_b;
      3'b001:  alu_result <= alu_a - alu_b;
      3'b010:  alu_result <= alu_a & alu_b;
      3'b011:  alu_result <= alu_a | alu_b;
      3'b100:  alu_result <= ~alu_a;
      default: alu_result <= '0;
    endcase
  end

  always @(negedge clk) begin
    if (cq.res_valid) begin
      log_d.push_back(cq.res_data);
      log_o.push_back(cq.res_op);
      log_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    cq.in_valid = 1'b1;
    cq.in_op    = op;
    cq.in_a     = a;
    cq.in_b     = b;
    step();
    cq.in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_o.delete();
    log_c.delete();
  endtask

  int cp;
  logic [3:0] exp3 [4];

  initial begin
    rst = 1'b1;
    issue_en = 1'b0;
    cq.in_valid = 1'b0;
    cq.in_op = '0;
    cq.in_a = '0;
    cq.in_b = '0;
    step();
    check("rst_in_ready", 32'(cq.in_ready), 1);
    repeat (2) step();
    rst = 1'b0;
    step();

    // 1: reset state
    check("init_in_ready", 32'(cq.in_ready), 1);
    check("init_level", 32'(level), 0);
    check("init_res_valid", 32'(cq.res_valid), 0);
    check("init_err", 32'(err_illegal), 0);
    check("init_alu_op", 32'(alu_op), 0);

    // 2: two adds, latency and wrap
    clear_log();
    issue_en = 1'b1;
    push(3'b000, 4'd3, 4'd5);
    cp = cyc;
    push(3'b000, 4'd15, 4'd1);
    repeat (6) step();
    check("t2_count", 32'(log_d.size()), 2);
    if (log_d.size() == 2) begin
      check("t2_d0", 32'(log_d[0]), 32'h8);
      check("t2_d1", 32'(log_d[1]), 32'h0);
      check("t2_o0", 32'(log_o[0]), 0);
      check("t2_o1", 32'(log_o[1]), 0);
      check("t2_lat0", 32'(log_c[0] - cp), 3);
      check("t2_lat1", 32'(log_c[1] - cp), 4);
    end

    // 3: sub/and/or/not back to back
    clear_log();
    push(3'b001, 4'd1, 4'd2);
    push(3'b010, 4'b1100, 4'b1010);
    push(3'b011, 4'b1100, 4'b1010);
    push(3'b100, 4'b0101, 4'b0000);
    repeat (8) step();
    exp3[0] = 4'hF; exp3[1] = 4'b1000; exp3[2] = 4'b1110; exp3[3] = 4'b1010;
    check("t3_count", 32'(log_d.size()), 4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t3_d%0d", i), 32'(log_d[i]), 32'(exp3[i]));
        check($sformatf("t3_o%0d", i), 32'(log_o[i]), 32'(i + 1));
        check($sformatf("t3_c%0d", i), 32'(log_c[i] - log_c[0]), 32'(i));
      end
    end

    // 4: stall fills the queue, then sustained push+pop
    clear_log();
    issue_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(3'b000, 4'(k + 1), 4'd1);
      check($sformatf("t4_rdy%0d", k), 32'(cq.in_ready), (k < 3) ? 1 : 0);
    end
    check("t4_full_level", 32'(level), 4);
    push(3'b000, 4'd5, 4'd1);
    check("t4_blocked_level", 32'(level), 4);
    check("t4_no_res_stalled", 32'(log_d.size()), 0);
    issue_en = 1'b1;
    cq.in_valid = 1'b1;
    step();
    check("t4_first_pop", 32'(level), 3);
    push(3'b000, 4'd5, 4'd1);
    check("t4_pp5", 32'(level), 3);
    push(3'b000, 4'd6, 4'd1);
    check("t4_pp6", 32'(level), 3);
    push(3'b000, 4'd7, 4'd1);
    check("t4_pp7", 32'(level), 3);
    repeat (10) step();
    check("t4_drained", 32'(level), 0);
    check("t4_count", 32'(log_d.size()), 7);
    if (log_d.size() == 7)
      for (int i = 0; i < 7; i++) check($sformatf("t4_d%0d", i), 32'(log_d[i]), 32'(i + 2));
    check("t4_hold_a", 32'(alu_a), 7);
    check("t4_hold_b", 32'(alu_b), 1);

    // 5: reset with three queued and one in flight
    clear_log();
    issue_en = 1'b0;
    for (int k = 0; k < 4; k++) push(3'b011, 4'(k + 1), 4'd0);
    issue_en = 1'b1;
    step();
    issue_en = 1'b0;
    check("t5_pre_level", 32'(level), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("t5_no_res", 32'(log_d.size()), 0);
    check("t5_level", 32'(level), 0);
    check("t5_in_ready", 32'(cq.in_ready), 1);

    // 6: illegal opcode
    clear_log();
    issue_en = 1'b1;
`ifdef ALU_OPCODE_CHECK_EN
    push(3'b110, 4'd3, 4'd3);
    check("t6_level", 32'(level), 0);
    check("t6_err", 32'(err_illegal), 1);
    push(3'b000, 4'd1, 4'd1);
    repeat (5) step();
    check("t6_err_sticky", 32'(err_illegal), 1);
    check("t6_count", 32'(log_d.size()), 1);
    if (log_d.size() == 1) check("t6_d0", 32'(log_d[0]), 2);
`else
    push(3'b110, 4'd3, 4'd3);
    check("t6_level", 32'(level), 1);
    repeat (5) step();
    check("t6_err", 32'(err_illegal), 0);
    check("t6_count", 32'(log_d.size()), 1);
    if (log_d.size() == 1) begin
      check("t6_o0", 32'(log_o[0]), 6);
      check("t6_d0", 32'(log_d[0]), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
